// File: rtl/coin_dispatch_ctrl.sv
// coin_dispatch_ctrl: synchronises and debounces the coin sensor, queues detected
// coins, and issues one fire request per coin to the shooter with a busy handshake,
// a post-shot hold-off gap and sticky fault/overflow flags.
module coin_dispatch_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned QUEUE_DEPTH     = 7,
    parameter int unsigned ACK_CYCLES      = 16,
    parameter int unsigned TIMEOUT_CYCLES  = 40000000,
    parameter int unsigned HOLDOFF_CYCLES  = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       coin_sensor,
    input  logic       shooter_busy,
    input  logic       clr,
    output logic       fire,
    output logic [2:0] pending,
    output logic       overflow,
    output logic       fault,
    output logic [2:0] state_dbg
);

    localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int unsigned WaitW = 26;

    localparam logic [DbW-1:0]   DbLast      = DbW'(DEBOUNCE_CYCLES - 1);
    localparam logic [WaitW-1:0] AckLast     = WaitW'(ACK_CYCLES - 1);
    localparam logic [WaitW-1:0] TimeoutLast = WaitW'(TIMEOUT_CYCLES - 1);
    localparam logic [WaitW-1:0] HoldLast    = WaitW'(HOLDOFF_CYCLES - 1);
    localparam logic [2:0]       QueueMax    = 3'(QUEUE_DEPTH);

    typedef enum logic [2:0] {
        StIdle     = 3'd0,
        StFire     = 3'd1,
        StWaitAck  = 3'd2,
        StWaitDone = 3'd3,
        StHoldoff  = 3'd4,
        StFault    = 3'd5
    } state_e;

    logic           sync_meta_q, sync_q;
    logic           acc_q, acc_d;
    logic [DbW-1:0] db_cnt_q, db_cnt_d;
    logic           coin_evt_q, coin_evt_d;
    logic [2:0]     pending_q, pending_d;
    logic           ovf_q, ovf_d;
    state_e         state_q, state_d;
    logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
    logic           fire_w;

    // Two-flop synchroniser for the asynchronous sensor input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_meta_q <= 1'b0;
            sync_q      <= 1'b0;
        end else begin
            sync_meta_q <= coin_sensor;
            sync_q      <= sync_meta_q;
        end
    end

    // Debouncer: accept a new level only after it has been stable long enough.
    always_comb begin
        acc_d      = acc_q;
        db_cnt_d   = '0;
        coin_evt_d = 1'b0;
        if (sync_q != acc_q) begin
            if (db_cnt_q == DbLast) begin
                acc_d      = ~acc_q;
                coin_evt_d = ~acc_q;  // only a 0->1 acceptance counts as a coin
            end else begin
                db_cnt_d = db_cnt_q + 1'b1;
            end
        end
    end

    // Pending-coin counter and sticky overflow; a coin arriving on a fire cycle cancels out.
    always_comb begin
        pending_d = pending_q;
        ovf_d     = clr ? 1'b0 : ovf_q;
        if (coin_evt_q && !fire_w) begin
            if (pending_q < QueueMax) begin
                pending_d = pending_q + 3'd1;
            end else begin
                ovf_d = 1'b1;  // set wins over a coincident clr
            end
        end else if (fire_w && !coin_evt_q) begin
            pending_d = pending_q - 3'd1;
        end
    end

    // Shot sequencer next-state and shared wait counter.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:     if (pending_q != 3'd0) state_d = StFire;
            StFire:     state_d = StWaitAck;
            StWaitAck: begin
                if (shooter_busy)               state_d = StWaitDone;
                else if (wait_cnt_q == AckLast) state_d = StFault;
            end
            StWaitDone: begin
                if (!shooter_busy)                  state_d = StHoldoff;
                else if (wait_cnt_q == TimeoutLast) state_d = StFault;
            end
            StHoldoff:  if (wait_cnt_q == HoldLast) state_d = StIdle;
            StFault:    if (clr) state_d = StIdle;
            default:    state_d = StIdle;
        endcase

        if (state_d != state_q) begin
            wait_cnt_d = '0;
        end else if (state_q inside {StWaitAck, StWaitDone, StHoldoff}) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end else begin
            wait_cnt_d = wait_cnt_q;
        end
    end

    // State registers for debouncer, queue and sequencer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q      <= 1'b0;
            db_cnt_q   <= '0;
            coin_evt_q <= 1'b0;
            pending_q  <= 3'd0;
            ovf_q      <= 1'b0;
            state_q    <= StIdle;
            wait_cnt_q <= '0;
        end else begin
            acc_q      <= acc_d;
            db_cnt_q   <= db_cnt_d;
            coin_evt_q <= coin_evt_d;
            pending_q  <= pending_d;
            ovf_q      <= ovf_d;
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign fire_w    = (state_q == StFire);
    assign fire      = fire_w;
    assign pending   = pending_q;
    assign overflow  = ovf_q;
    assign fault     = (state_q == StFault);
    assign state_dbg = state_q;

endmodule

// File: tb/tb_coin_dispatch_ctrl.sv
// tb_coin_dispatch_ctrl: scenario table, directed corner-case sequences and a
// randomized run checked every cycle against a timestamp-based reference model.
`timescale 1ns/1ps
module tb_coin_dispatch_ctrl;

    localparam int DB  = 4;
    localparam int QD  = 3;
    localparam int ACK = 8;
    localparam int TO  = 100;
    localparam int HO  = 10;

    localparam int SIdle = 0, SFire = 1, SWaitAck = 2, SWaitDone = 3, SHold = 4, SFault = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       coin_sensor = 1'b0;
    logic       shooter_busy = 1'b0;
    logic       clr = 1'b0;
    logic       fire, overflow, fault;
    logic [2:0] pending, state_dbg;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    coin_dispatch_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .QUEUE_DEPTH    (QD),
        .ACK_CYCLES     (ACK),
        .TIMEOUT_CYCLES (TO),
        .HOLDOFF_CYCLES (HO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .coin_sensor (coin_sensor),
        .shooter_busy(shooter_busy),
        .clr         (clr),
        .fire        (fire),
        .pending     (pending),
        .overflow    (overflow),
        .fault       (fault),
        .state_dbg   (state_dbg)
    );

    // Shooter behaviour: busy rises sh_delay samples after fire, stays high sh_hold
    // samples (0 = never rises, -1 = stuck high).
    int sh_delay = 3;
    int sh_hold  = 50;
    int rise_in  = 0;
    int high_left = 0;
    int fires    = 0;
    int max_pend = 0;

    // Reference model state (timestamps instead of counters).
    bit model_on = 0;
    int m_state, m_pend, m_edge, m_entered;
    bit m_ovf, m_evt, m_acc;
    bit raw_hist[$];
    bit win[$];
    int rand_prints = 0;

    typedef struct {
        int coins; int delay; int hold;
        int exp_fires; int exp_pend; int exp_ovf; int exp_fault; int exp_state;
    } case_t;
    case_t tbl[8];

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = SIdle; m_pend = 0; m_edge = 0; m_entered = 0;
        m_ovf = 0; m_evt = 0; m_acc = 0;
        raw_hist = '{1'b0, 1'b0};
        win.delete();
    endtask

    task automatic model_edge();
        bit fire_now, evt_now, sb, flip, set_ovf;
        int old_pend, nxt, elapsed;
        fire_now = (m_state == SFire);
        evt_now  = m_evt;
        old_pend = m_pend;
        set_ovf  = 0;
        // Level seen by the debouncer is the raw sample from two edges ago.
        sb = raw_hist[0];
        raw_hist.push_back(coin_sensor);
        void'(raw_hist.pop_front());
        win.push_back(sb);
        if (win.size() > DB) void'(win.pop_front());
        flip = (win.size() == DB);
        foreach (win[i]) if (win[i] == m_acc) flip = 0;
        m_evt = flip && !m_acc;
        if (flip) begin
            m_acc = !m_acc;
            win.delete();
        end
        if (evt_now && !fire_now) begin
            if (m_pend < QD) m_pend++;
            else set_ovf = 1;
        end else if (fire_now && !evt_now) begin
            m_pend--;
        end
        if (clr) m_ovf = 0;
        if (set_ovf) m_ovf = 1;
        m_edge++;
        elapsed = m_edge - m_entered;
        nxt = m_state;
        case (m_state)
            SIdle:     if (old_pend != 0) nxt = SFire;
            SFire:     nxt = SWaitAck;
            SWaitAck:  if (shooter_busy) nxt = SWaitDone; else if (elapsed == ACK) nxt = SFault;
            SWaitDone: if (!shooter_busy) nxt = SHold; else if (elapsed == TO) nxt = SFault;
            SHold:     if (elapsed == HO) nxt = SIdle;
            SFault:    if (clr) nxt = SIdle;
            default:   nxt = SIdle;
        endcase
        if (nxt != m_state) begin
            m_state   = nxt;
            m_entered = m_edge;
        end
    endtask

    task automatic model_check();
        bit ok;
        ok = (fire == (m_state == SFire)) && (int'(pending) == m_pend) && (overflow == m_ovf)
             && (fault == (m_state == SFault)) && (int'(state_dbg) == m_state);
        total++;
        if (!ok) begin
            bad++;
            if (rand_prints < 20) begin
                rand_prints++;
                $display("FAIL rand edge=%0d got fire=%0d pend=%0d ovf=%0d fault=%0d st=%0d want fire=%0d pend=%0d ovf=%0d fault=%0d st=%0d",
                         m_edge, fire, pending, overflow, fault, state_dbg,
                         (m_state == SFire), m_pend, m_ovf, (m_state == SFault), m_state);
            end
        end
    endtask

    // One clock: model sees inputs at the edge, DUT is sampled 1 ns later, then
    // the shooter model reacts.
    task automatic tick();
        @(posedge clk);
        if (model_on) model_edge();
        #1;
        if (model_on) model_check();
        if (fire) fires++;
        if (int'(pending) > max_pend) max_pend = pending;
        if (fire) begin
            rise_in = sh_delay;
        end else if (rise_in > 0) begin
            rise_in--;
            if (rise_in == 0 && sh_hold != 0) begin
                shooter_busy = 1'b1;
                high_left = sh_hold;
            end
        end else if (shooter_busy && high_left > 0) begin
            high_left--;
            if (high_left == 0) shooter_busy = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0; coin_sensor = 1'b0; shooter_busy = 1'b0; clr = 1'b0;
        rise_in = 0; high_left = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fires = 0; max_pend = 0;
        model_reset();
    endtask

    task automatic coin(input int hi, input int lo);
        coin_sensor = 1'b1;
        repeat (hi) tick();
        coin_sensor = 1'b0;
        repeat (lo) tick();
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, n2, seg_left;

        // coins, delay, hold -> fires, pending, overflow, fault, state
        tbl[0] = '{1, 3, 50,  1, 0, 0, 0, SIdle};
        tbl[1] = '{2, 2, 5,   2, 0, 0, 0, SIdle};
        tbl[2] = '{5, 1, 90,  4, 0, 1, 0, SIdle};
        tbl[3] = '{1, 3, 0,   1, 0, 0, 1, SFault};
        tbl[4] = '{2, 3, 0,   1, 1, 0, 1, SFault};
        tbl[5] = '{1, 2, -1,  1, 0, 0, 1, SFault};
        tbl[6] = '{1, 8, 5,   1, 0, 0, 0, SIdle};
        tbl[7] = '{1, 9, 5,   1, 0, 0, 1, SFault};

        // Reset values
        rst_n = 1'b0;
        #12;
        check("reset fire", fire, 0);
        check("reset pending", pending, 0);
        check("reset overflow", overflow, 0);
        check("reset fault", fault, 0);
        check("reset state", state_dbg, SIdle);

        // Scenario table
        for (int i = 0; i < 8; i++) begin
            do_reset();
            sh_delay = tbl[i].delay;
            sh_hold  = tbl[i].hold;
            for (int c = 0; c < tbl[i].coins; c++) coin(8, 8);
            repeat (800) tick();
            check($sformatf("case%0d fires", i), fires, tbl[i].exp_fires);
            check($sformatf("case%0d pending", i), pending, tbl[i].exp_pend);
            check($sformatf("case%0d overflow", i), overflow, tbl[i].exp_ovf);
            check($sformatf("case%0d fault", i), fault, tbl[i].exp_fault);
            check($sformatf("case%0d state", i), state_dbg, tbl[i].exp_state);
        end

        // Single coin latency and fire-to-fire spacing after busy falls
        do_reset();
        sh_delay = 3; sh_hold = 50;
        coin_sensor = 1'b1;
        repeat (6) tick();
        check("single pend before evt", pending, 0);
        tick();
        check("single pend after evt", pending, 1);
        check("single no early fire", fire, 0);
        tick();
        check("single fire", fire, 1);
        check("single pend at fire", pending, 1);
        tick();
        check("single fire one cycle", fire, 0);
        check("single pend after fire", pending, 0);
        check("single state wait_ack", state_dbg, SWaitAck);
        repeat (11) tick();
        coin_sensor = 1'b0;
        repeat (8) tick();
        coin(8, 8);
        check("spacing queued", pending, 1);
        n = 0;
        while (shooter_busy && n < 200) begin
            tick();
            n++;
        end
        n2 = 0;
        while (n2 < 40) begin
            tick();
            n2++;
            if (fire) break;
        end
        check("spacing busy fall to fire", n2, 12);
        check("spacing fires", fires, 2);
        check("spacing fault", fault, 0);

        // Debounce: short glitch rejected, long pulse accepted once
        do_reset();
        sh_delay = 3; sh_hold = 20;
        coin_sensor = 1'b1;
        repeat (3) tick();
        coin_sensor = 1'b0;
        repeat (10) tick();
        check("glitch no coin", max_pend, 0);
        coin_sensor = 1'b1;
        repeat (10) tick();
        coin_sensor = 1'b0;
        repeat (150) tick();
        check("debounce peak pending", max_pend, 1);
        check("debounce fires", fires, 1);
        check("debounce pending end", pending, 0);

        // Ack timeout timing, fire suppression in fault, coincident evt/fire, clr vs overflow
        do_reset();
        sh_delay = 3; sh_hold = 0;
        coin_sensor = 1'b1;
        repeat (10) tick();
        coin_sensor = 1'b0;
        repeat (6) tick();
        check("ack wait state", state_dbg, SWaitAck);
        check("ack not yet fault", fault, 0);
        tick();
        check("ack timeout fault", fault, 1);
        check("ack timeout state", state_dbg, SFault);
        repeat (3) coin(8, 8);
        check("fault queue pending", pending, 3);
        check("fault no fire", fires, 1);
        check("fault no overflow", overflow, 0);
        coin_sensor = 1'b1;
        repeat (4) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("clr to idle", state_dbg, SIdle);
        tick();
        check("simul fire", fire, 1);
        check("simul pending at fire", pending, 3);
        tick();
        check("simul pending kept", pending, 3);
        check("simul no overflow", overflow, 0);
        check("simul wait_ack", state_dbg, SWaitAck);
        coin_sensor = 1'b0;
        repeat (12) tick();
        check("simul refault", fault, 1);
        coin_sensor = 1'b1;
        repeat (6) tick();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("set wins overflow", overflow, 1);
        check("set wins pending", pending, 3);
        check("set wins state", state_dbg, SIdle);
        tick();
        check("fire after clr", fire, 1);
        coin_sensor = 1'b0;

        // Done timeout timing
        do_reset();
        sh_delay = 2; sh_hold = -1;
        coin_sensor = 1'b1;
        repeat (10) tick();
        coin_sensor = 1'b0;
        repeat (100) tick();
        check("done wait state", state_dbg, SWaitDone);
        tick();
        check("done timeout fault", fault, 1);
        check("done timeout state", state_dbg, SFault);

        // Asynchronous reset mid WAIT_DONE discards the queue
        do_reset();
        sh_delay = 2; sh_hold = -1;
        coin(8, 8);
        coin(8, 8);
        check("pre-reset state", state_dbg, SWaitDone);
        check("pre-reset pending", pending, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async rst fire", fire, 0);
        check("async rst pending", pending, 0);
        check("async rst overflow", overflow, 0);
        check("async rst fault", fault, 0);
        check("async rst state", state_dbg, SIdle);
        shooter_busy = 1'b0; rise_in = 0; high_left = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        fires = 0;
        repeat (30) tick();
        check("post-reset no fire", fires, 0);
        check("post-reset pending", pending, 0);

        // Randomized run against the reference model
        do_reset();
        model_on = 1;
        seg_left = 0;
        for (int c = 0; c < 4000; c++) begin
            if (seg_left == 0) begin
                coin_sensor = 1'($urandom_range(0, 1));
                seg_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 4))
                                                       : int'($urandom_range(5, 40));
            end
            seg_left--;
            clr = ($urandom_range(0, 59) == 0);
            sh_delay = ($urandom_range(0, 9) == 0) ? 9 : int'($urandom_range(1, 8));
            case ($urandom_range(0, 14))
                0:       sh_hold = 0;
                1:       sh_hold = 120;
                default: sh_hold = int'($urandom_range(1, 30));
            endcase
            tick();
        end
        model_on = 0;
        clr = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
